mem_stage: RTL and testbench

- MEM pipeline stage plus ME/WB pipeline register.
- Consumes the EX/ME register outputs, performs the data-memory access over a req/ack data bus, selects write-back data, and registers the WB-stage control and data.
- Asserts ME_Stall while an access is outstanding; the hazard unit uses it to freeze IF/ID/EX and the EX/ME register.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_bus_fsm.sv | 115 +++++++++++
 rtl/mem_stage.sv | 119 +++++++++++
 tb/tb_mem_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mips_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned VAL_W              = 64;
  localparam int unsigned REG_W              = 5;
  localparam int unsigned WCNT_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  // Write-back data source select
  localparam logic WD_SRC_ALU = 1'b0;
  localparam logic WD_SRC_MEM = 1'b1;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  // Force an effective address onto a word boundary
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-bus request/ack sequencer for the MEM stage.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_bus_fsm
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            dbus_ack,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic            done_c,
  output logic            err_c,
  output logic            stall_c
);

  mem_state_e      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

`ifdef MEM_TIMEOUT_EN
  logic [WCNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^WCNT_W'(TIMEOUT_CYCLES);
`endif

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;

  // Next-state, bus register and stall/completion decode
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_c  = 1'b0;
    err_c   = 1'b0;
    stall_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      MEM_IDLE: begin
        if (start_i) begin
          stall_c = 1'b1;
          state_d = MEM_BUSY;
          req_d   = 1'b1;
          we_d    = we_i;
          addr_d  = word_addr(addr_i);
          wdata_d = wdata_i;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      MEM_BUSY: begin
        if (dbus_ack) begin
          done_c  = 1'b1;
          state_d = MEM_IDLE;
          req_d   = 1'b0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_c   = 1'b1;
          state_d = MEM_IDLE;
          req_d   = 1'b0;
        end
`endif
        else begin
          stall_c = 1'b1;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + WCNT_W'(1);
`endif
        end
      end
    endcase
  end

  // State and bus registers; reset drops any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with ME/WB register.
// Define MEM_TIMEOUT_EN to enable the data-bus watchdog and WB_BusErr.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  EXMEVal,
  input  logic              ME_DMWr,
  input  logic              ME_DMRd,
  input  logic              ME_RFWr,
  input  logic              ME_WD_Src,
  input  logic [XLEN-1:0]   ME_ALURes,
  input  logic [REG_W-1:0]  ME_Rd,
  input  logic [XLEN-1:0]   ME_RTVal,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_ack,
  input  logic [XLEN-1:0]   dbus_rdata,
  output logic              ME_Stall,
  output logic [VAL_W-1:0]  MEWBVal,
  output logic              WB_RFWr,
  output logic [REG_W-1:0]  WB_Rd,
  output logic [XLEN-1:0]   WB_WD,
  output logic              WB_AdrErr,
  output logic              WB_BusErr
);

  logic acc_c, misalign_c, start_c;
  logic done_c, err_c, stall_c;

  logic [VAL_W-1:0] val_q, val_d;
  logic             rfwr_q, rfwr_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  wd_q, wd_d;
  logic             adrerr_q, adrerr_d;
  logic             buserr_q, buserr_d;

  assign acc_c      = ME_DMRd | ME_DMWr;
  assign misalign_c = acc_c & (ME_ALURes[1:0] != 2'b00);
  assign start_c    = acc_c & ~misalign_c;
  assign ME_Stall   = stall_c;

  // A simultaneous read+write is issued as a write
  mem_bus_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_fsm (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_c),
    .we_i       (ME_DMWr),
    .addr_i     (ME_ALURes),
    .wdata_i    (ME_RTVal),
    .dbus_ack   (dbus_ack),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .done_c     (done_c),
    .err_c      (err_c),
    .stall_c    (stall_c)
  );

  // WB register next value: completion, timeout, bubble, misaligned or pass-through
  always_comb begin
    val_d    = EXMEVal;
    rfwr_d   = ME_RFWr;
    rd_d     = ME_Rd;
    wd_d     = ME_ALURes;
    adrerr_d = 1'b0;
    buserr_d = 1'b0;
    if (done_c) begin
      rfwr_d = ME_RFWr & ~ME_DMWr;
      wd_d   = (ME_WD_Src == WD_SRC_MEM) ? dbus_rdata : ME_ALURes;
    end else if (err_c) begin
      rfwr_d   = 1'b0;
      buserr_d = 1'b1;
    end else if (stall_c) begin
      val_d  = '0;
      rfwr_d = 1'b0;
      rd_d   = '0;
      wd_d   = '0;
    end else if (misalign_c) begin
      rfwr_d   = 1'b0;
      adrerr_d = 1'b1;
    end
  end

  // ME/WB pipeline register, loaded every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= '0;
      rfwr_q   <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
      adrerr_q <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      rfwr_q   <= rfwr_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
      adrerr_q <= adrerr_d;
      buserr_q <= buserr_d;
    end
  end

  assign MEWBVal   = val_q;
  assign WB_RFWr   = rfwr_q;
  assign WB_Rd     = rd_q;
  assign WB_WD     = wd_q;
  assign WB_AdrErr = adrerr_q;
  assign WB_BusErr = buserr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] EXMEVal;
  logic        ME_DMWr, ME_DMRd, ME_RFWr, ME_WD_Src;
  logic [31:0] ME_ALURes, ME_RTVal;
  logic [4:0]  ME_Rd;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        ME_Stall;
  logic [63:0] MEWBVal;
  logic        WB_RFWr;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_WD;
  logic        WB_AdrErr, WB_BusErr;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .EXMEVal    (EXMEVal),
    .ME_DMWr    (ME_DMWr),
    .ME_DMRd    (ME_DMRd),
    .ME_RFWr    (ME_RFWr),
    .ME_WD_Src  (ME_WD_Src),
    .ME_ALURes  (ME_ALURes),
    .ME_Rd      (ME_Rd),
    .ME_RTVal   (ME_RTVal),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_rdata (dbus_rdata),
    .ME_Stall   (ME_Stall),
    .MEWBVal    (MEWBVal),
    .WB_RFWr    (WB_RFWr),
    .WB_Rd      (WB_Rd),
    .WB_WD      (WB_WD),
    .WB_AdrErr  (WB_AdrErr),
    .WB_BusErr  (WB_BusErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic wr, input logic rd, input logic rfwr, input logic src,
                        input logic [31:0] alu, input logic [4:0] rdst,
                        input logic [31:0] rt, input logic [63:0] val);
    ME_DMWr   = wr;
    ME_DMRd   = rd;
    ME_RFWr   = rfwr;
    ME_WD_Src = src;
    ME_ALURes = alu;
    ME_Rd     = rdst;
    ME_RTVal  = rt;
    EXMEVal   = val;
  endtask

  initial begin
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = '0;
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);
    tick();
    tick();
    // Reset state
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_val", MEWBVal, 0);
    chk("rst_rfwr", WB_RFWr, 0);
    chk("rst_rd", WB_Rd, 0);
    chk("rst_wd", WB_WD, 0);
    chk("rst_adrerr", WB_AdrErr, 0);
    chk("rst_buserr", WB_BusErr, 0);
    rst = 1'b0;

    // ALU pass-through
    set_in(0, 0, 1, 0, 32'h1234, 5'd5, 32'h0, 64'h1111_2222_3333_4444);
    #1 chk("alu_stall", ME_Stall, 0);
    tick();
    chk("alu_rfwr", WB_RFWr, 1);
    chk("alu_rd", WB_Rd, 5);
    chk("alu_wd", WB_WD, 32'h1234);
    chk("alu_val", MEWBVal, 64'h1111_2222_3333_4444);
    chk("alu_req", dbus_req, 0);
    chk("alu_adrerr", WB_AdrErr, 0);

    // Load, ack on the fourth BUSY cycle
    set_in(0, 1, 1, 1, 32'h100, 5'd7, 32'h0, 64'hAAAA_0000_0000_0001);
    #1 chk("ld_stall0", ME_Stall, 1);
    tick();
    chk("ld_req", dbus_req, 1);
    chk("ld_addr", dbus_addr, 32'h100);
    chk("ld_we", dbus_we, 0);
    chk("ld_bubble", WB_RFWr, 0);
    chk("ld_stall1", ME_Stall, 1);
    tick();
    chk("ld_stall2", ME_Stall, 1);
    tick();
    chk("ld_stall3", ME_Stall, 1);
    chk("ld_req3", dbus_req, 1);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", ME_Stall, 0);
    tick();
    dbus_ack = 1'b0;
    chk("ld_req_done", dbus_req, 0);
    chk("ld_wd", WB_WD, 32'hDEADBEEF);
    chk("ld_rfwr", WB_RFWr, 1);
    chk("ld_rd", WB_Rd, 7);
    chk("ld_val", MEWBVal, 64'hAAAA_0000_0000_0001);
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);

    // Store, ack after one BUSY cycle
    set_in(1, 0, 1, 0, 32'h204, 5'd9, 32'hCAFE0001, 64'h2);
    #1 chk("st_stall0", ME_Stall, 1);
    tick();
    chk("st_req", dbus_req, 1);
    chk("st_we", dbus_we, 1);
    chk("st_wdata", dbus_wdata, 32'hCAFE0001);
    chk("st_addr", dbus_addr, 32'h204);
    chk("st_stall1", ME_Stall, 1);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'h5555_5555;
    #1 chk("st_stall_ack", ME_Stall, 0);
    tick();
    dbus_ack = 1'b0;
    chk("st_req_done", dbus_req, 0);
    chk("st_rfwr", WB_RFWr, 0);
    chk("st_wd", WB_WD, 32'h204);
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);

    // Stray ack while idle is ignored
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    chk("idle_ack_req", dbus_req, 0);

    // Misaligned load
    set_in(0, 1, 1, 1, 32'h102, 5'd3, 32'h0, 64'h3);
    #1 chk("mis_stall", ME_Stall, 0);
    tick();
    chk("mis_req", dbus_req, 0);
    chk("mis_adrerr", WB_AdrErr, 1);
    chk("mis_rfwr", WB_RFWr, 0);
    chk("mis_rd", WB_Rd, 3);
    chk("mis_wd", WB_WD, 32'h102);
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);
    tick();
    chk("mis_clear", WB_AdrErr, 0);

    // Reset in the middle of a load, then the same load completes
    set_in(0, 1, 1, 1, 32'h40, 5'd4, 32'h0, 64'h4);
    tick();
    chk("rb_req", dbus_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_req_rst", dbus_req, 0);
    chk("rb_rfwr", WB_RFWr, 0);
    chk("rb_wd", WB_WD, 0);
    chk("rb_val", MEWBVal, 0);
    chk("rb_addr", dbus_addr, 0);
    #1 chk("rb_stall", ME_Stall, 1);
    tick();
    chk("rb_req2", dbus_req, 1);
    chk("rb_addr2", dbus_addr, 32'h40);
    dbus_ack = 1'b1;
    dbus_rdata = 32'h0000_55AA;
    tick();
    dbus_ack = 1'b0;
    chk("rb_wd2", WB_WD, 32'h55AA);
    chk("rb_rfwr2", WB_RFWr, 1);

    // Back-to-back loads: one idle gap on dbus_req
    set_in(0, 1, 1, 1, 32'h80, 5'd10, 32'h0, 64'h80);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'h1;
    tick();
    dbus_ack = 1'b0;
    chk("b2b_wd1", WB_WD, 32'h1);
    chk("b2b_gap", dbus_req, 0);
    set_in(0, 1, 1, 1, 32'h84, 5'd11, 32'h0, 64'h84);
    #1 chk("b2b_stall", ME_Stall, 1);
    tick();
    chk("b2b_req2", dbus_req, 1);
    chk("b2b_addr2", dbus_addr, 32'h84);
    dbus_ack = 1'b1;
    dbus_rdata = 32'h2;
    tick();
    dbus_ack = 1'b0;
    chk("b2b_wd2", WB_WD, 32'h2);
    chk("b2b_rd2", WB_Rd, 11);

    // Read+write together is a write with no register write-back
    set_in(1, 1, 1, 1, 32'h88, 5'd12, 32'h77, 64'h88);
    tick();
    chk("rw_we", dbus_we, 1);
    dbus_ack = 1'b1;
    dbus_rdata = 32'h9;
    tick();
    dbus_ack = 1'b0;
    chk("rw_rfwr", WB_RFWr, 0);
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Watchdog forces completion on the eighth BUSY cycle
    set_in(0, 1, 1, 1, 32'h10, 5'd2, 32'h0, 64'h10);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("to_stall", ME_Stall, 1);
      chk("to_req", dbus_req, 1);
      tick();
    end
    chk("to_stall_last", ME_Stall, 0);
    tick();
    chk("to_req_drop", dbus_req, 0);
    chk("to_buserr", WB_BusErr, 1);
    chk("to_rfwr", WB_RFWr, 0);
    set_in(0, 0, 0, 0, 32'h0, 5'd0, 32'h0, 64'h0);
    tick();
    chk("to_clear", WB_BusErr, 0);
`else
    chk("no_buserr", WB_BusErr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
